// File: rtl/memwb_lsu.sv
// rtl/memwb_lsu.sv - memory-stage load/store unit and MEM/WB register (optional MEM_TIMEOUT_EN)
module memwb_lsu #(
   parameter int MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   // EX/MEM side
   input  logic        regWrtm,
   input  logic        memWrtm,
   input  logic        readm,
   input  logic [1:0]  rsltSrcm,
   input  logic [2:0]  funct3m,
   input  logic [31:0] aluRsltm,
   input  logic [31:0] wrtDm,
   input  logic [31:0] pc4m,
   input  logic [31:0] ujWrtBckm,
   input  logic [4:0]  rdm,
   // data-memory bus
   output logic        dReq,
   output logic        dWe,
   output logic [31:0] dAddr,
   output logic [31:0] dWdata,
   output logic [3:0]  dBe,
   input  logic [31:0] dRdata,
   input  logic        dAck,
   // pipeline control
   output logic        stallm,
   // MEM/WB register
   output logic        regWrtw,
   output logic [1:0]  rsltSrcw,
   output logic [31:0] aluRsltw,
   output logic [31:0] readDataw,
   output logic [31:0] pc4w,
   output logic [31:0] ujWrtBckw,
   output logic [4:0]  rdw,
   output logic        errw
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state;
   state_t      state_nxt;

   logic        access;
   logic        illegal;
   logic        misaligned;
   logic        bad_acc;
   logic        legal;
   logic        abort;
   logic        err_now;
   logic [3:0]  lane_be;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;

   // Classify the incoming access: legal, illegal encoding or misaligned.
   always_comb begin
      access     = memWrtm | readm;
      illegal    = 1'b0;
      misaligned = 1'b0;
      if (memWrtm && readm) begin
         illegal = 1'b1;
      end else if (readm) begin
         illegal = !(funct3m inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end else if (memWrtm) begin
         illegal = funct3m[2] | (funct3m[1:0] == 2'b11);
      end
      case (funct3m[1:0])
         2'b01:   misaligned = aluRsltm[0];
         2'b10:   misaligned = |aluRsltm[1:0];
         default: misaligned = 1'b0;
      endcase
      bad_acc = access & (illegal | misaligned);
      legal   = access & ~bad_acc;
   end

`ifdef MEM_TIMEOUT_EN
   // The request cycle in IDLE counts as the first stalled cycle, so the
   // abort lands on the WAIT cycle whose count reaches MAX_WAIT-1 and the
   // pipeline is held for exactly MAX_WAIT cycles.
   localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);
   localparam logic [7:0] CNT_SAT   = 8'(MAX_WAIT);

   logic [7:0] wait_cnt;

   assign abort = (state == WAIT) && !dAck && (wait_cnt == LAST_WAIT);

   // Count unacknowledged WAIT cycles; held at zero outside WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= 8'd0;
      end else if (state == IDLE) begin
         wait_cnt <= 8'd0;
      end else if (!dAck && (wait_cnt != CNT_SAT)) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end
`else
   assign abort = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: enter WAIT when a legal request is not acked at once.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (legal && !dAck) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (dAck || abort) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Bus request and store lanes. Upstream is frozen by stallm while in
   // WAIT, so the bus fields stay constant without extra holding flops.
   // Reset masks the request combinationally so it drops immediately.
   always_comb begin
      dReq = 1'b0;
      if (rst_n) begin
         if (state == WAIT) begin
            dReq = ~abort;
         end else begin
            dReq = legal;
         end
      end
      stallm  = dReq & ~dAck;
      dWe     = dReq & memWrtm;
      dAddr   = {aluRsltm[31:2], 2'b00};
      dWdata  = wrtDm;
      lane_be = 4'b1111;
      case (funct3m[1:0])
         2'b00: begin
            dWdata  = {4{wrtDm[7:0]}};
            lane_be = 4'b0001 << aluRsltm[1:0];
         end
         2'b01: begin
            dWdata  = {2{wrtDm[15:0]}};
            lane_be = aluRsltm[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            dWdata  = wrtDm;
            lane_be = 4'b1111;
         end
      endcase
      dBe = dReq ? lane_be : 4'b0000;
   end

   // Load alignment: pick the addressed byte/halfword and extend it.
   always_comb begin
      case (aluRsltm[1:0])
         2'b00:   byte_sel = dRdata[7:0];
         2'b01:   byte_sel = dRdata[15:8];
         2'b10:   byte_sel = dRdata[23:16];
         default: byte_sel = dRdata[31:24];
      endcase
      half_sel = aluRsltm[1] ? dRdata[31:16] : dRdata[15:0];
      case (funct3m)
         3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_data = {24'd0, byte_sel};
         3'b101:  load_data = {16'd0, half_sel};
         default: load_data = dRdata;
      endcase
   end

   assign err_now = bad_acc | abort;

   // MEM/WB register: bubble while stalled, otherwise capture the bundle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regWrtw   <= 1'b0;
         rsltSrcw  <= 2'd0;
         aluRsltw  <= 32'd0;
         readDataw <= 32'd0;
         pc4w      <= 32'd0;
         ujWrtBckw <= 32'd0;
         rdw       <= 5'd0;
         errw      <= 1'b0;
      end else if (stallm) begin
         regWrtw <= 1'b0;
         errw    <= 1'b0;
      end else begin
         regWrtw   <= regWrtm & ~err_now;
         rsltSrcw  <= rsltSrcm;
         aluRsltw  <= aluRsltm;
         readDataw <= load_data;
         pc4w      <= pc4m;
         ujWrtBckw <= ujWrtBckm;
         rdw       <= rdm;
         errw      <= err_now;
      end
   end

endmodule
